// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if
// Bundles the three buses that meet at the VRAM arbiter: the video fetch
// port, the CPU write port and the single-port VRAM itself.
// Parameters: AW (address width), DW (data width), DEPTH (CPU write FIFO entries).
// Modports:
//   slave  - the arbiter: takes requests and ram_dout, drives acks, status and the RAM port
//   master - the surroundings (video generator, Z80 decode, VRAM model)
interface vram_arbiter_if #(
  parameter int AW    = 13,
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_data;

  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_wait;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  vid_req, vid_addr, cpu_we, cpu_addr, cpu_din, ram_dout,
    output vid_ack, vid_data, cpu_wait, overflow, fifo_level,
           ram_addr, ram_din, ram_we
  );

  modport master (
    output vid_req, vid_addr, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  vid_ack, vid_data, cpu_wait, overflow, fifo_level,
           ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares the single-port video RAM between the video fetcher and CPU writes.
// Video reads win every cycle they are requested; CPU writes are queued in a
// small in-order FIFO and drained into cycles with no video request.
// Ports:
//   i_clk - ULA clock, single domain
//   i_rst - asynchronous, active-high reset
//   bus   - vram_arbiter_if.slave: video port (vid_*), CPU write port
//           (cpu_*, overflow, fifo_level) and registered VRAM port (ram_*)
module vram_arbiter #(
  parameter int AW    = 13,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] r_fifo_addr [DEPTH];
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic          r_rd_v1;
  logic          r_rd_v2;
  logic          r_vid_ack;
  logic [DW-1:0] r_vid_data;

  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic          r_ram_we;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  // A write arriving while full is dropped even if this edge pops an entry:
  // the decision uses the registered level only.
  assign w_push  = bus.cpu_we && !w_full;
  assign w_pop   = !bus.vid_req && !w_empty;

  // FIFO storage needs no reset; validity is carried by the level counter.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.cpu_addr;
      r_fifo_data[r_wr_ptr] <= bus.cpu_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_rd_v1    <= 1'b0;
      r_rd_v2    <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_vid_data <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      // Slot decision: video read, else drain one FIFO entry, else idle.
      if (bus.vid_req) begin
        r_ram_addr <= bus.vid_addr;
        r_ram_we   <= 1'b0;
      end else if (!w_empty) begin
        r_ram_addr <= r_fifo_addr[r_rd_ptr];
        r_ram_din  <= r_fifo_data[r_rd_ptr];
        r_ram_we   <= 1'b1;
      end else begin
        r_ram_we   <= 1'b0;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      if (bus.cpu_we && w_full) r_overflow <= 1'b1;

      // v1: address is on the RAM port; v2: RAM has sampled it and ram_dout
      // is valid; the following edge captures the data and raises the ack.
      r_rd_v1   <= bus.vid_req;
      r_rd_v2   <= r_rd_v1;
      r_vid_ack <= r_rd_v2;
      if (r_rd_v2) r_vid_data <= bus.ram_dout;
    end
  end

  assign bus.vid_ack    = r_vid_ack;
  assign bus.vid_data   = r_vid_data;
  assign bus.cpu_wait   = w_full;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = r_level;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.ram_we     = r_ram_we;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model
// and a log of every RAM write cycle.
module tb_vram_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  vram_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous read-first VRAM model.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  logic [AW-1:0] wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wlog_a.push_back(bus.ram_addr);
      wlog_d.push_back(bus.ram_din);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " vid_ack"},    32'(bus.vid_ack),    0);
    check({tag, " vid_data"},   32'(bus.vid_data),   0);
    check({tag, " cpu_wait"},   32'(bus.cpu_wait),   0);
    check({tag, " overflow"},   32'(bus.overflow),   0);
    check({tag, " fifo_level"}, 32'(bus.fifo_level), 0);
    check({tag, " ram_addr"},   32'(bus.ram_addr),   0);
    check({tag, " ram_din"},    32'(bus.ram_din),    0);
    check({tag, " ram_we"},     32'(bus.ram_we),     0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[13'h1800] = 8'hA5;
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h10 + i);

    rst          = 1'b1;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single read
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h1800;
    tick();
    bus.vid_req = 1'b0;
    check("rd1 ram_addr", 32'(bus.ram_addr), 32'h1800);
    check("rd1 ram_we e0", 32'(bus.ram_we), 0);
    check("rd1 ack e0", 32'(bus.vid_ack), 0);
    tick();
    check("rd1 ack e1", 32'(bus.vid_ack), 0);
    check("rd1 ram_we e1", 32'(bus.ram_we), 0);
    tick();
    check("rd1 ack e2", 32'(bus.vid_ack), 1);
    check("rd1 data", 32'(bus.vid_data), 32'hA5);
    check("rd1 ram_we e2", 32'(bus.ram_we), 0);
    tick();
    check("rd1 ack e3", 32'(bus.vid_ack), 0);
    check("rd1 data held", 32'(bus.vid_data), 32'hA5);

    // Pipelined reads of 0x0000..0x0003
    for (int k = 0; k < 6; k++) begin
      bus.vid_req  = (k < 4);
      bus.vid_addr = AW'(k < 4 ? k : 0);
      tick();
      check($sformatf("pipe ack e%0d", k), 32'(bus.vid_ack), (k >= 2) ? 1 : 0);
      if (k >= 2) check($sformatf("pipe data e%0d", k), 32'(bus.vid_data), 32'(8'h10 + k - 2));
    end
    bus.vid_req = 1'b0;

    // Write drain held off by 6 cycles of video reads
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h0000;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 13'h0100;
    bus.cpu_din  = 8'h55;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.cpu_we = 1'b0;
      check($sformatf("drain ram_we e%0d", k), 32'(bus.ram_we), 0);
      check($sformatf("drain level e%0d", k), 32'(bus.fifo_level), 1);
    end
    bus.vid_req = 1'b0;
    tick();
    check("drain ram_we", 32'(bus.ram_we), 1);
    check("drain ram_addr", 32'(bus.ram_addr), 32'h0100);
    check("drain ram_din", 32'(bus.ram_din), 32'h55);
    check("drain level 0", 32'(bus.fifo_level), 0);
    tick();
    check("drain ram_we off", 32'(bus.ram_we), 0);

    // Full / overflow
    wlog_a.delete();
    wlog_d.delete();
    bus.vid_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(13'h0200 + i);
      bus.cpu_din  = DW'(8'h60 + i);
      tick();
      check($sformatf("full level w%0d", i), 32'(bus.fifo_level), (i < 4) ? i + 1 : 4);
      check($sformatf("full wait w%0d", i), 32'(bus.cpu_wait), (i >= 3) ? 1 : 0);
      check($sformatf("full ovf w%0d", i), 32'(bus.overflow), (i == 4) ? 1 : 0);
      check($sformatf("full ram_we w%0d", i), 32'(bus.ram_we), 0);
    end
    bus.cpu_we  = 1'b0;
    bus.vid_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("full drained count", 32'(wlog_a.size()), 4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      check($sformatf("full order addr %0d", i), 32'(wlog_a[i]), 32'(13'h0200 + i));
      check($sformatf("full order data %0d", i), 32'(wlog_d[i]), 32'(8'h60 + i));
    end
    check("full ovf sticky", 32'(bus.overflow), 1);
    check("full level 0", 32'(bus.fifo_level), 0);
    check("full wait 0", 32'(bus.cpu_wait), 0);

    // Push and pop on the same edge, across pointer wrap
    wlog_a.delete();
    wlog_d.delete();
    bus.vid_req = 1'b1;
    for (int j = 0; j < 2; j++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(13'h0300 + j);
      bus.cpu_din  = DW'(8'h80 + j);
      tick();
    end
    check("pp setup level", 32'(bus.fifo_level), 2);
    bus.vid_req = 1'b0;
    for (int j = 2; j < 10; j++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(13'h0300 + j);
      bus.cpu_din  = DW'(8'h80 + j);
      tick();
      check($sformatf("pp level w%0d", j), 32'(bus.fifo_level), 2);
    end
    bus.cpu_we = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pp level end", 32'(bus.fifo_level), 0);
    check("pp count", 32'(wlog_a.size()), 10);
    for (int i = 0; i < 10 && i < wlog_a.size(); i++) begin
      check($sformatf("pp order addr %0d", i), 32'(wlog_a[i]), 32'(13'h0300 + i));
      check($sformatf("pp order data %0d", i), 32'(wlog_d[i]), 32'(8'h80 + i));
    end

    // Asynchronous reset with level=3 and reads in flight
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h1800;
    for (int j = 0; j < 3; j++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(13'h0400 + j);
      bus.cpu_din  = DW'(8'hC0 + j);
      tick();
    end
    bus.cpu_we = 1'b0;
    check("rst pre level", 32'(bus.fifo_level), 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst async");
    bus.vid_req = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst hold ack %0d", k), 32'(bus.vid_ack), 0);
      check($sformatf("rst hold ram_we %0d", k), 32'(bus.ram_we), 0);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h1800;
    tick();
    bus.vid_req = 1'b0;
    check("post rst ram_addr", 32'(bus.ram_addr), 32'h1800);
    check("post rst ack e0", 32'(bus.vid_ack), 0);
    tick();
    check("post rst ack e1", 32'(bus.vid_ack), 0);
    tick();
    check("post rst ack e2", 32'(bus.vid_ack), 1);
    check("post rst data", 32'(bus.vid_data), 32'hA5);
    check("post rst level", 32'(bus.fifo_level), 0);
    check("post rst no writes", 32'(wlog_a.size()), 0);
    check("post rst ovf", 32'(bus.overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB video RAM between the video fetcher and CPU screen writes. Video reads have absolute priority and are serviced every cycle they are requested. CPU writes are buffered in a small in-order FIFO and drained into idle RAM cycles. The block sits between the Z80 bus decode in the ULA, the video generator and the VRAM instance, all on the 14 MHz ULA clock.

## Interface
Parameters:
- AW, 13, VRAM address width
- DW, 8, data width
- DEPTH, 4, CPU write FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  ULA clock (14 MHz); single clock domain
- RESET  in  1  asynchronous, active-high reset
- vid_req  in  1  video read request, sampled every rising CLK edge
- vid_addr  in  AW  video read address, valid with vid_req
- vid_ack  out  1  one-cycle pulse: vid_data holds the read result
- vid_data  out  DW  read data, held until the next vid_ack
- cpu_we  in  1  single-cycle write strobe, already synchronous to CLK
- cpu_addr  in  AW  write address, valid with cpu_we
- cpu_din  in  DW  write data, valid with cpu_we
- cpu_wait  out  1  FIFO full; upstream must hold off cpu_we
- overflow  out  1  sticky: a write was dropped; cleared only by RESET
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- ram_addr  out  AW  VRAM address, registered
- ram_din  out  DW  VRAM write data, registered
- ram_we  out  1  VRAM write enable, registered
- ram_dout  in  DW  VRAM read data; synchronous RAM, one cycle after ram_addr

## Operation
- **Reset values (all outputs):** vid_ack=0, vid_data=0, cpu_wait=0, overflow=0, fifo_level=0, ram_addr=0, ram_din=0, ram_we=0. FIFO pointers=0. Read pipeline valid bits=0.
- **Slot decision, every edge, priority order:**
  - vid_req=1: issue a read. ram_addr<=vid_addr, ram_we<=0, set pipeline stage-1 valid.
  - otherwise, FIFO not empty: issue a write. ram_addr<=head addr, ram_din<=head data, ram_we<=1, pop.
  - otherwise: idle. ram_we<=0; ram_addr and ram_din hold.
- **Read pipeline:**
  - Stage 1 marks the RAM access.
  - Stage 2 captures vid_data<=ram_dout and pulses vid_ack.
  - Back-to-back requests are fully pipelined: one ack per request, in order.
- **FIFO:**
  - Circular buffer of {addr,data}, strictly in order.
  - Writes never coalesce.
  - No forwarding: a video read of an address with a pending write returns the old RAM contents.
- **Push rules:**
  - cpu_we with registered level < DEPTH: push.
  - cpu_we with level == DEPTH: write dropped, overflow<=1, FIFO unchanged. This holds even if a pop occurs in the same cycle.
- **Simultaneous push and pop** (level not full): level unchanged, both pointers advance.
- **cpu_wait** = (fifo_level == DEPTH), combinational from the registered level.
- **Starvation:** continuous vid_req stalls the FIFO indefinitely. This is by design; the video timing guarantees gaps every 8 cycles.
- **Pointer wrap:** pointers wrap modulo DEPTH; level is tracked separately, so full and empty are unambiguous.

## Timing
- **Video read latency:**
  - vid_req sampled at edge n.
  - ram_addr valid after edge n.
  - RAM data after edge n+1.
  - vid_ack=1 and vid_data valid after edge n+2, for one cycle.
- **Write latency:** with the FIFO empty and no vid_req, cpu_we at edge n appears as ram_we=1 after edge n+1. The push and the write never occur on the same edge.
- **RAM port:** ram_we is high for exactly one cycle per drained entry.
- **Asynchronous RESET mid-operation:**
  - Pending FIFO entries are discarded.
  - In-flight reads produce no ack.
  - ram_we drops immediately.
  - First activity after release is at the first edge with RESET low.

## Test plan
- **Single read:** RAM[0x1800]=0xA5; vid_req one cycle with vid_addr=0x1800 -> vid_ack exactly 2 edges later, vid_data=0xA5, ram_we=0 throughout.
- **Pipelined reads:** vid_req held 4 cycles, addresses 0x0000–0x0003 holding 0x10–0x13 -> 4 consecutive vid_ack pulses with data 0x10,0x11,0x12,0x13.
- **Write drain with video priority:**
  - Stimulus: cpu_we to 0x0100=0x55 while vid_req is held for 6 cycles.
  - Required: ram_we stays 0 during those cycles, then pulses once with ram_addr=0x0100, ram_din=0x55; fifo_level returns 1->0.
- **Full/overflow:**
  - With vid_req held, issue 5 writes (DEPTH=4).
  - Required: cpu_wait=1 after the 4th, the 5th is dropped, overflow=1, fifo_level=4.
  - Release vid_req: 4 ram_we pulses in push order; overflow stays 1.
- **Push+pop same cycle:**
  - Setup: level=2, vid_req=0.
  - Stimulus: cpu_we on the next edge.
  - Required: level stays 2 for that edge, then drains; write order preserved across pointer wrap (send 10 writes total).
- **Async reset mid-operation:**
  - Stimulus: assert RESET between edges with level=3 and a read in flight.
  - Required: all outputs immediately at reset values, no vid_ack; after release, one read completes normally in 2 cycles.
